// File: rtl/safe_cmd_fsm_pkg.sv
// Shared encodings for the safety command FSM: state codes, command codes
// and a helper that tells whether a state accepts commands.
package safe_cmd_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_ARM  = 3'b011,
    ST_RUN  = 3'b101,
    ST_HOLD = 3'b110,
    ST_SAFE = 3'b111
  } state_e;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_ARM    = 3'd1,
    CMD_START  = 3'd2,
    CMD_PAUSE  = 3'd3,
    CMD_RESUME = 3'd4,
    CMD_STOP   = 3'd5,
    CMD_CLEAR  = 3'd6
  } cmd_e;

  localparam logic [2:0] ERR_SAT = 3'd7;

  // Operational states count undefined commands; SAFE and illegal codes do not.
  function automatic logic is_op_state(input logic [2:0] s);
    logic r;
    case (s)
      ST_IDLE, ST_ARM, ST_RUN, ST_HOLD: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/safe_cmd_tmr.sv
// RUN-phase timer: clear has priority over enable, otherwise holds.
// Expiry flags the last allowed RUN cycle (count == TMO_MAX-1).
module safe_cmd_tmr #(
  parameter int TMO_W   = 4,
  parameter int TMO_MAX = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [TMO_W-1:0] o_cnt,
  output logic             o_exp
);

  localparam logic [TMO_W-1:0] EXP_VAL = TMO_W'(TMO_MAX - 1);

  logic [TMO_W-1:0] r_cnt;

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_exp = (r_cnt == EXP_VAL);

endmodule

// File: rtl/safe_cmd_fsm.sv
// Safety command sequencer: IDLE/ARM/RUN/HOLD/SAFE with a RUN timeout,
// illegal-command counting and recovery of corrupted state encodings.
module safe_cmd_fsm
  import safe_cmd_fsm_pkg::*;
#(
  parameter int CMD_W     = 3,
  parameter int TMO_W     = 4,
  parameter int TMO_MAX   = 10,
  parameter int ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  output logic [2:0]       state_o,
  output logic             active,
  output logic             illegal_cmd,
  output logic             timeout,
  output logic             fault,
  output logic [2:0]       err_cnt
);

  localparam logic [CMD_W-1:0] UNDEF_MIN = CMD_W'(7);
  localparam logic [2:0]       ERR_LIM   = 3'(ERR_LIMIT);

  logic [2:0]       r_state;
  logic             r_active;
  logic             r_ill;
  logic             r_to;
  logic             r_fault;
  logic [2:0]       r_err;

  logic [2:0]       w_next;
  logic             w_ill;
  logic             w_to;
  logic             w_fault_next;
  logic [2:0]       w_err_next;
  logic [2:0]       w_err_inc;
  logic             w_lim;
  logic             w_undef;
  logic             w_cmd_ok;
  cmd_e             w_code;
  logic             w_tmr_clr;
  logic             w_tmr_en;
  logic             w_tmr_exp;
  logic [TMO_W-1:0] w_tmr_cnt;

  assign w_undef  = cmd_valid && (cmd >= UNDEF_MIN);
  assign w_cmd_ok = cmd_valid && !w_undef;
  assign w_code   = cmd_e'(cmd[2:0]);

  safe_cmd_tmr #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_tmr_clr),
    .i_en  (w_tmr_en),
    .o_cnt (w_tmr_cnt),
    .o_exp (w_tmr_exp)
  );

  // Next-state, flag and counter decisions in priority order
  always_comb begin
    w_next       = r_state;
    w_ill        = 1'b0;
    w_to         = 1'b0;
    w_fault_next = r_fault;
    w_err_next   = r_err;
    w_tmr_clr    = 1'b0;
    w_tmr_en     = (r_state == ST_RUN);
    w_lim        = 1'b0;
    w_err_inc    = (r_err == ERR_SAT) ? ERR_SAT : (r_err + 3'd1);

    if (w_undef && is_op_state(r_state)) begin
      w_ill      = 1'b1;
      w_err_next = w_err_inc;
      w_lim      = (w_err_inc >= ERR_LIM);
    end else begin
      w_lim      = 1'b0;
    end

    if (w_lim) begin
      w_next       = ST_SAFE;
      w_fault_next = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_ok && (w_code == CMD_ARM)) w_next = ST_ARM;
          else                                 w_next = ST_IDLE;
        end
        ST_ARM: begin
          if (w_cmd_ok && (w_code == CMD_START)) begin
            w_next    = ST_RUN;
            w_tmr_clr = 1'b1;
          end else if (w_cmd_ok && (w_code == CMD_STOP)) begin
            w_next = ST_IDLE;
          end else begin
            w_next = ST_ARM;
          end
        end
        ST_RUN: begin
          // An applicable command on the expiry cycle wins over the timeout
          if (w_cmd_ok && (w_code == CMD_PAUSE)) begin
            w_next = ST_HOLD;
          end else if (w_cmd_ok && (w_code == CMD_STOP)) begin
            w_next = ST_IDLE;
          end else if (w_tmr_exp) begin
            w_next = ST_IDLE;
            w_to   = 1'b1;
          end else begin
            w_next = ST_RUN;
          end
        end
        ST_HOLD: begin
          if (w_cmd_ok && (w_code == CMD_RESUME))    w_next = ST_RUN;
          else if (w_cmd_ok && (w_code == CMD_STOP)) w_next = ST_IDLE;
          else                                       w_next = ST_HOLD;
        end
        ST_SAFE: begin
          if (w_cmd_ok && (w_code == CMD_CLEAR)) begin
            w_next       = ST_IDLE;
            w_fault_next = 1'b0;
            w_err_next   = 3'd0;
          end else begin
            w_next = ST_SAFE;
          end
        end
        default: begin
          w_next       = ST_SAFE;
          w_fault_next = 1'b1;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
      r_ill    <= 1'b0;
      r_to     <= 1'b0;
      r_fault  <= 1'b0;
      r_err    <= 3'd0;
    end else begin
      r_state  <= w_next;
      r_active <= (w_next == ST_RUN);
      r_ill    <= w_ill;
      r_to     <= w_to;
      r_fault  <= w_fault_next;
      r_err    <= w_err_next;
    end
  end

  assign state_o     = r_state;
  assign active      = r_active;
  assign illegal_cmd = r_ill;
  assign timeout     = r_to;
  assign fault       = r_fault;
  assign err_cnt     = r_err;

endmodule

// File: tb/tb_safe_cmd_fsm.sv
// Self-checking bench for safe_cmd_fsm: directed vector table, corner-case
// sequences and randomized commands against a behavioural reference model.
module tb_safe_cmd_fsm;

  localparam int TMO_MAX = 10;
  localparam int LIM     = 3;
  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_ARM  = 3'b011;
  localparam logic [2:0] S_RUN  = 3'b101;
  localparam logic [2:0] S_HOLD = 3'b110;
  localparam logic [2:0] S_SAFE = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [2:0] state_o;
  logic       active, illegal_cmd, timeout, fault;
  logic [2:0] err_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: run_age counts RUN cycles since START, paused in HOLD
  logic [2:0] m_state;
  int         m_age, m_err;
  logic       m_fault, m_ill, m_to;

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic [2:0] st;
    logic       ill;
    logic       to;
    logic       flt;
    logic [2:0] err;
  } vec_t;

  vec_t tbl[$];

  safe_cmd_fsm #(.CMD_W(3), .TMO_W(4), .TMO_MAX(TMO_MAX), .ERR_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
    .state_o(state_o), .active(active), .illegal_cmd(illegal_cmd),
    .timeout(timeout), .fault(fault), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] dut_vec();
    return {state_o, active, illegal_cmd, timeout, fault, err_cnt};
  endfunction

  function automatic logic [9:0] model_vec();
    return {m_state, (m_state == S_RUN), m_ill, m_to, m_fault, 3'(m_err)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_age = 0; m_err = 0; m_fault = 1'b0; m_ill = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_apply(input logic v, input logic [2:0] c);
    int  code;
    bit  undef, lim;
    code  = v ? int'(c) : 0;
    undef = v && (c >= 3'd7);
    m_ill = 1'b0; m_to = 1'b0; lim = 1'b0;
    if (!(m_state inside {S_IDLE, S_ARM, S_RUN, S_HOLD, S_SAFE})) begin
      m_state = S_SAFE; m_fault = 1'b1;
    end else if (m_state == S_SAFE) begin
      if (code == 6) begin m_state = S_IDLE; m_fault = 1'b0; m_err = 0; end
    end else begin
      if (undef) begin
        m_ill = 1'b1;
        m_err = (m_err < 7) ? m_err + 1 : 7;
        lim   = (m_err >= LIM);
      end
      if (lim) begin
        m_state = S_SAFE; m_fault = 1'b1;
      end else if (m_state == S_IDLE) begin
        if (code == 1) m_state = S_ARM;
      end else if (m_state == S_ARM) begin
        if (code == 2) begin m_state = S_RUN; m_age = 0; end
        else if (code == 5) m_state = S_IDLE;
      end else if (m_state == S_RUN) begin
        if (code == 3) begin m_state = S_HOLD; m_age++; end
        else if (code == 5) m_state = S_IDLE;
        else if (m_age == TMO_MAX - 1) begin m_state = S_IDLE; m_to = 1'b1; end
        else m_age++;
      end else begin
        if (code == 4) m_state = S_RUN;
        else if (code == 5) m_state = S_IDLE;
      end
    end
  endtask

  task automatic step(input logic v, input logic [2:0] c);
    @(negedge clk);
    cmd_valid = v; cmd = c;
    model_apply(v, c);
    @(posedge clk);
    #1;
  endtask

  task automatic mstep(input string name, input logic v, input logic [2:0] c);
    step(v, c);
    chk(name, 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0;
    #1;
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic v, input logic [2:0] c, input logic [2:0] st,
                     input logic ill, input logic to, input logic flt, input logic [2:0] err);
    vec_t e;
    e.v = v; e.c = c; e.st = st; e.ill = ill; e.to = to; e.flt = flt; e.err = err;
    tbl.push_back(e);
  endtask

  initial begin
    // Directed table starting from IDLE after reset
    add(1, 7, S_IDLE, 1, 0, 0, 1);
    add(1, 7, S_IDLE, 1, 0, 0, 2);
    add(1, 7, S_SAFE, 1, 0, 1, 3);
    add(1, 2, S_SAFE, 0, 0, 1, 3);
    add(1, 7, S_SAFE, 0, 0, 1, 3);
    add(0, 6, S_SAFE, 0, 0, 1, 3);
    add(1, 6, S_IDLE, 0, 0, 0, 0);
    add(1, 2, S_IDLE, 0, 0, 0, 0);
    add(1, 1, S_ARM,  0, 0, 0, 0);
    add(1, 4, S_ARM,  0, 0, 0, 0);
    add(1, 5, S_IDLE, 0, 0, 0, 0);
    add(1, 1, S_ARM,  0, 0, 0, 0);
    add(0, 2, S_ARM,  0, 0, 0, 0);
    add(1, 2, S_RUN,  0, 0, 0, 0);
    add(1, 3, S_HOLD, 0, 0, 0, 0);
    add(1, 6, S_HOLD, 0, 0, 0, 0);
    add(1, 4, S_RUN,  0, 0, 0, 0);
    add(1, 7, S_RUN,  1, 0, 0, 1);
    add(1, 5, S_IDLE, 0, 0, 0, 1);
    add(1, 1, S_ARM,  0, 0, 0, 1);
    add(1, 2, S_RUN,  0, 0, 0, 1);
    add(1, 3, S_HOLD, 0, 0, 0, 1);
    add(1, 5, S_IDLE, 0, 0, 0, 1);

    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].c);
      chk($sformatf("tbl[%0d]", i), 32'(dut_vec()),
          32'({tbl[i].st, (tbl[i].st == S_RUN), tbl[i].ill, tbl[i].to, tbl[i].flt, tbl[i].err}));
    end

    // Timeout after START: 9 idle cycles stay in RUN, 10th returns to IDLE
    do_reset();
    mstep("tmo_arm", 1, 1);
    mstep("tmo_start", 1, 2);
    for (int k = 1; k <= 9; k++) mstep($sformatf("tmo_run%0d", k), 0, 0);
    chk("tmo_still_run", 32'(state_o), 32'(S_RUN));
    mstep("tmo_expire", 0, 0);
    chk("tmo_idle", 32'({state_o, timeout}), 32'({S_IDLE, 1'b1}));
    mstep("tmo_pulse_end", 0, 0);
    chk("tmo_one_cycle", 32'(timeout), 32'd0);

    // Pause in 4th RUN cycle, hold 20 cycles, timeout 6 cycles after RESUME
    mstep("pz_arm", 1, 1);
    mstep("pz_start", 1, 2);
    for (int k = 1; k <= 3; k++) mstep("pz_run", 0, 0);
    mstep("pz_pause", 1, 3);
    for (int k = 1; k <= 20; k++) mstep("pz_hold", 0, 0);
    chk("pz_in_hold", 32'(state_o), 32'(S_HOLD));
    mstep("pz_resume", 1, 4);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0);
      chk($sformatf("pz_tmo_after%0d", k), 32'(timeout), 32'(k == 6));
    end

    // STOP on the expiry cycle wins over the timeout
    mstep("st_arm", 1, 1);
    mstep("st_start", 1, 2);
    for (int k = 1; k <= 9; k++) mstep("st_run", 0, 0);
    mstep("st_stop", 1, 5);
    chk("st_no_timeout", 32'({state_o, timeout}), 32'({S_IDLE, 1'b0}));

    // Corrupted state encoding recovers to SAFE with fault
    @(negedge clk);
    cmd_valid = 1'b0; cmd = 3'd0;
    force dut.r_state = 3'b001;
    #2;
    chk("force_seen", 32'(state_o), 32'd1);
    release dut.r_state;
    m_state = 3'b001;
    model_apply(1'b0, 3'd0);
    @(posedge clk);
    #1;
    chk("illegal_enc_safe", 32'({state_o, fault}), 32'({S_SAFE, 1'b1}));
    chk("illegal_enc_model", 32'(dut_vec()), 32'(model_vec()));
    mstep("illegal_clear", 1, 6);

    // Asynchronous reset in the middle of RUN
    mstep("ar_arm", 1, 1);
    mstep("ar_start", 1, 2);
    for (int k = 1; k <= 3; k++) mstep("ar_run", 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_zero", 32'(dut_vec()), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mstep("post_reset_arm", 1, 1);

    // Randomized commands against the reference model
    for (int k = 0; k < 400; k++) begin
      logic       v;
      logic [2:0] c;
      v = ($urandom_range(0, 4) != 0);
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) c = 3'($urandom_range(1, 5));
      mstep($sformatf("rand%0d", k), v, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
